vit_seq_322: RTL and testbench

Step sequencer for the (3,2,2) Viterbi decoder. Accepts received 3-bit code symbols over a valid/ready handshake and presents each one to the branch-metric unit with a one-cycle load enable. It then holds the ACS stage enabled for a programmable number of cycles per trellis step. It counts steps per frame and hands off to the traceback unit at frame end. It sits between the channel/symbol input and the branch-metric, ACS and traceback stages.

---
 rtl/vit_seq_322_pkg.sv | 20 ++
 rtl/vit_seq_322_if.sv | 9 +
 rtl/vit_step_timer_322.sv | 37 +++
 rtl/vit_seq_322.sv | 93 +++++++++
 tb/tb_vit_seq_322.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vit_seq_322_pkg.sv
// vit322_pkg: shared (3,2,2) Viterbi code constants, sequencer state encoding and width helper
package vit322_pkg;
  localparam int N       = 3;
  localparam int K       = 2;
  localparam int M       = 2;
  localparam int NSTATES = 1 << M;
  localparam int TMR_W   = 3;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ACS,
    ST_WAIT,
    ST_TB,
    ST_TBWAIT,
    ST_DONE
  } seq_state_e;
  function automatic int step_w(input int frame_len);
    return $clog2(frame_len + 1);
  endfunction
endpackage

// File: rtl/vit_seq_322_if.sv
// vit_seq_322_if: received-symbol valid/ready channel into the sequencer
interface vit_seq_322_if;
  logic [2:0] sym_in;
  logic       sym_valid;
  logic       sof;
  logic       sym_ready;
  modport master (output sym_in, output sym_valid, output sof, input sym_ready);
  modport slave  (input sym_in, input sym_valid, input sof, output sym_ready);
endinterface

// File: rtl/vit_step_timer_322.sv
// vit_step_timer_322: trellis step counter and per-step ACS cycle timer
module vit_step_timer_322
  import vit322_pkg::*;
#(
  parameter int FRAME_LEN  = 64,
  parameter int ACS_CYCLES = 1,
  localparam int STEP_W    = step_w(FRAME_LEN)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clr,
  input  logic              inc,
  input  logic              load,
  input  logic              run,
  output logic [STEP_W-1:0] step_cnt,
  output logic              last,
  output logic              zero
);
  logic [STEP_W-1:0] step_q, step_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  always_comb begin
    step_d = clr ? '0 : inc ? step_q + 1'b1 : step_q;
    tmr_d  = load ? TMR_W'(ACS_CYCLES - 1) : (run && tmr_q != '0) ? tmr_q - 1'b1 : tmr_q;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      step_q <= '0;
      tmr_q  <= '0;
    end else begin
      step_q <= step_d;
      tmr_q  <= tmr_d;
    end
  end
  assign step_cnt = step_q;
  assign last     = step_q == STEP_W'(FRAME_LEN - 1);
  assign zero     = tmr_q == '0;
endmodule

// File: rtl/vit_seq_322.sv
// vit_seq_322: sequences symbol load, ACS steps and traceback handoff for one frame
module vit_seq_322
  import vit322_pkg::*;
#(
  parameter int FRAME_LEN  = 64,
  parameter int ACS_CYCLES = 1,
  localparam int STEP_W    = step_w(FRAME_LEN)
) (
  input  logic              clock,
  input  logic              reset,
  vit_seq_322_if.slave      sym_if,
  output logic [2:0]        Rx,
  output logic              le,
  output logic              acs_en,
  output logic              acs_first,
  output logic [STEP_W-1:0] step_cnt,
  output logic              tb_start,
  input  logic              tb_done,
  output logic              busy,
  output logic              frame_done,
  output logic              err_sof
);
  seq_state_e state_q, state_d;
  logic [2:0] rx_q, rx_d;
  logic       err_q, err_d;
  logic       hs, clr, inc, last, zero;
  vit_step_timer_322 #(
    .FRAME_LEN (FRAME_LEN),
    .ACS_CYCLES(ACS_CYCLES)
  ) u_timer (
    .clock   (clock),
    .reset   (reset),
    .clr     (clr),
    .inc     (inc),
    .load    (state_q == ST_LOAD),
    .run     (state_q == ST_ACS),
    .step_cnt(step_cnt),
    .last    (last),
    .zero    (zero)
  );
  // ready is forced low while reset is held even though the state already reads IDLE
  assign sym_if.sym_ready = ~reset & (state_q == ST_IDLE || state_q == ST_WAIT);
  always_comb begin
    hs      = sym_if.sym_valid & sym_if.sym_ready;
    state_d = state_q;
    rx_d    = rx_q;
    err_d   = 1'b0;
    clr     = 1'b0;
    inc     = 1'b0;
    case (state_q)
      ST_IDLE: if (hs) begin
        err_d   = ~sym_if.sof;
        clr     = sym_if.sof;
        rx_d    = sym_if.sof ? sym_if.sym_in : rx_q;
        state_d = sym_if.sof ? ST_LOAD : ST_IDLE;
      end
      ST_LOAD: state_d = ST_ACS;
      ST_ACS: if (zero) begin
        inc     = ~last;
        state_d = last ? ST_TB : ST_WAIT;
      end
      ST_WAIT: if (hs) begin
        err_d   = sym_if.sof;
        clr     = sym_if.sof;
        rx_d    = sym_if.sym_in;
        state_d = ST_LOAD;
      end
      ST_TB:     state_d = ST_TBWAIT;
      ST_TBWAIT: state_d = tb_done ? ST_DONE : ST_TBWAIT;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      rx_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rx_q    <= rx_d;
      err_q   <= err_d;
    end
  end
  assign Rx         = rx_q;
  assign le         = state_q == ST_LOAD;
  assign acs_en     = state_q == ST_ACS;
  assign acs_first  = acs_en && step_cnt == '0;
  assign tb_start   = state_q == ST_TB;
  assign busy       = state_q != ST_IDLE;
  assign frame_done = state_q == ST_DONE;
  assign err_sof    = err_q;
endmodule

// File: tb/tb_vit_seq_322.sv
// tb_vit_seq_322: randomized trace check of two sequencer configs against a timeline model
module tb_vit_seq_322;
  localparam int L = 4;
  typedef struct packed {
    logic [2:0] rx;
    logic       le, acs, first;
    logic [2:0] step;
    logic       tbs, fd, rdy, busy, err;
    logic       v, f, tbd;
    logic [2:0] s;
  } slot_t;

  logic clock = 1'b0;
  logic reset;
  logic [1:0]      sv_i, sf_i, tbd_i;
  logic [1:0][2:0] sy_i;
  wire  [1:0][2:0] rx_o, step_o;
  wire  [1:0]      le_o, acs_o, fst_o, tbs_o, busy_o, fd_o, err_o, rdy_o;
  int errors = 0;
  int checks = 0;
  int A [2] = '{1, 3};
  logic [2:0] m_rx [2];
  int         m_step [2];
  slot_t      q[$];
  logic [2:0] b_sy[$];
  logic       b_sf[$];
  int         b_d, b_nxt;
  logic       b_err;

  always #5 clock = ~clock;

  vit_seq_322_if if0 ();
  vit_seq_322_if if1 ();
  assign if0.sym_in = sy_i[0];
  assign if0.sym_valid = sv_i[0];
  assign if0.sof = sf_i[0];
  assign if1.sym_in = sy_i[1];
  assign if1.sym_valid = sv_i[1];
  assign if1.sof = sf_i[1];
  assign rdy_o = {if1.sym_ready, if0.sym_ready};

  vit_seq_322 #(.FRAME_LEN(L), .ACS_CYCLES(1)) u0 (
    .clock(clock), .reset(reset), .sym_if(if0), .Rx(rx_o[0]), .le(le_o[0]), .acs_en(acs_o[0]),
    .acs_first(fst_o[0]), .step_cnt(step_o[0]), .tb_start(tbs_o[0]), .tb_done(tbd_i[0]),
    .busy(busy_o[0]), .frame_done(fd_o[0]), .err_sof(err_o[0])
  );
  vit_seq_322 #(.FRAME_LEN(L), .ACS_CYCLES(3)) u1 (
    .clock(clock), .reset(reset), .sym_if(if1), .Rx(rx_o[1]), .le(le_o[1]), .acs_en(acs_o[1]),
    .acs_first(fst_o[1]), .step_cnt(step_o[1]), .tb_start(tbs_o[1]), .tb_done(tbd_i[1]),
    .busy(busy_o[1]), .frame_done(fd_o[1]), .err_sof(err_o[1])
  );

  function automatic logic [13:0] obs(input int d);
    return {rx_o[d], le_o[d], acs_o[d], fst_o[d], step_o[d], tbs_o[d], fd_o[d], rdy_o[d], busy_o[d], err_o[d]};
  endfunction

  function automatic logic [13:0] expv(input slot_t e);
    return {e.rx, e.le, e.acs, e.first, e.step, e.tbs, e.fd, e.rdy, e.busy, e.err};
  endfunction

  function automatic slot_t sl(input logic le, acs, tbs, fd, rdy, busy, tbd);
    slot_t e = '0;
    e.le = le; e.acs = acs; e.tbs = tbs; e.fd = fd; e.rdy = rdy; e.busy = busy; e.tbd = tbd;
    return e;
  endfunction

  // one expected cycle: visible outputs plus the inputs the source drives toward the next edge
  task automatic add(input slot_t e);
    e.rx = m_rx[b_d];
    e.step = 3'(m_step[b_d]);
    e.first = e.acs && m_step[b_d] == 0;
    e.err = b_err;
    b_err = 1'b0;
    e.v = b_nxt < b_sy.size();
    e.s = e.v ? b_sy[b_nxt] : 3'd0;
    e.f = e.v ? b_sf[b_nxt] : 1'b0;
    if (e.rdy && e.v) b_nxt++;
    q.push_back(e);
  endtask

  // timeline: accepted beat -> le next cycle, A acs cycles, then WAIT or TB/TBWAIT/DONE
  task automatic build(input int d, input int tbw, input logic tie);
    logic idle = 1'b1;
    q.delete();
    b_d = d; b_nxt = 0; b_err = 1'b0;
    for (int k = 0; k < b_sy.size(); k++) begin
      add(sl(0, 0, 0, 0, 1, !idle, tie));
      if (idle && !b_sf[k]) begin
        b_err = 1'b1;
        continue;
      end
      b_err = !idle && b_sf[k];
      if (b_sf[k]) m_step[d] = 0;
      m_rx[d] = b_sy[k];
      idle = 1'b0;
      add(sl(1, 0, 0, 0, 0, 1, tie));
      for (int c = 0; c < A[d]; c++) add(sl(0, 1, 0, 0, 0, 1, tie));
      if (m_step[d] == L - 1) begin
        add(sl(0, 0, 1, 0, 0, 1, tbw > 0 ? 1'b1 : tie));
        for (int c = 0; c < tbw; c++) add(sl(0, 0, 0, 0, 0, 1, 0));
        add(sl(0, 0, 0, 0, 0, 1, 1));
        add(sl(0, 0, 0, 1, 0, 1, tie));
        idle = 1'b1;
      end else m_step[d]++;
    end
    add(sl(0, 0, 0, 0, 1, !idle, tie));
  endtask

  task automatic run(input int d, input string nm, input int nmax);
    for (int i = 0; i < q.size() && i < nmax; i++) begin
      checks++;
      if (obs(d) !== expv(q[i])) begin
        errors++;
        $display("FAIL %s dut%0d cycle %0d: got {rx,le,acs,first,step,tbs,fd,rdy,busy,err}=%b want %b",
                 nm, d, i, obs(d), expv(q[i]));
      end
      sv_i[d] = q[i].v; sy_i[d] = q[i].s; sf_i[d] = q[i].f; tbd_i[d] = q[i].tbd;
      @(posedge clock);
      @(negedge clock);
    end
    sv_i[d] = 1'b0;
  endtask

  task automatic frame_beats(input int nfr, input bit strays);
    b_sy.delete(); b_sf.delete();
    for (int f = 0; f < nfr; f++) begin
      if (strays && $urandom_range(1) == 1) begin
        b_sy.push_back(3'($urandom_range(7))); b_sf.push_back(1'b0);
      end
      for (int k = 0; k < L; k++) begin
        b_sy.push_back(3'($urandom_range(7))); b_sf.push_back(k == 0);
      end
    end
  endtask

  task automatic test_reset();
    logic [13:0] idle_v;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs(d) !== 14'd0) begin
        errors++; $display("FAIL reset_hold dut%0d: got %b want %b", d, obs(d), 14'd0);
      end
    end
    @(negedge clock);
    reset = 1'b0;
    m_rx = '{3'd0, 3'd0}; m_step = '{0, 0};
    #1;
    idle_v = expv(sl(0, 0, 0, 0, 1, 0, 0));
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs(d) !== idle_v) begin
        errors++; $display("FAIL reset_release dut%0d: got %b want %b", d, obs(d), idle_v);
      end
    end
    @(negedge clock);
    frame_beats(1, 0);
    build(1, 0, 1'b1);
    run(1, "pre_reset", 3);
    sv_i[1] = 1'b0;
    reset = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs(d) !== 14'd0) begin
        errors++; $display("FAIL reset_mid_acs dut%0d: got %b want %b", d, obs(d), 14'd0);
      end
    end
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    m_rx = '{3'd0, 3'd0}; m_step = '{0, 0};
    for (int c = 0; c < 6; c++) begin
      #1;
      checks++;
      if (obs(1) !== idle_v) begin
        errors++; $display("FAIL reset_after cycle %0d: got %b want %b", c, obs(1), idle_v);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_basic();
    b_sy = '{3'b101, 3'b000, 3'b111, 3'b011};
    b_sf = '{1'b1, 1'b0, 1'b0, 1'b0};
    build(0, 0, 1'b1);
    run(0, "basic", 1000);
  endtask

  task automatic test_acs3();
    frame_beats(1, 0);
    build(1, 0, 1'b0);
    run(1, "acs3", 1000);
  endtask

  task automatic test_idle_nosof();
    b_sy = '{3'($urandom_range(7)), 3'($urandom_range(7))};
    b_sf = '{1'b0, 1'b0};
    build(0, 0, 1'b0);
    run(0, "idle_nosof", 1000);
  endtask

  task automatic test_abort();
    b_sy.delete(); b_sf.delete();
    for (int k = 0; k < 6; k++) begin
      b_sy.push_back(3'($urandom_range(7)));
      b_sf.push_back(k == 0 || k == 2);
    end
    build(0, 0, 1'b1);
    run(0, "abort", 1000);
  endtask

  task automatic test_tbwait();
    frame_beats(1, 0);
    build(1, 10, 1'b0);
    run(1, "tbwait", 1000);
  endtask

  task automatic test_back_to_back();
    for (int d = 0; d < 2; d++) begin
      frame_beats(3, 1);
      build(d, $urandom_range(3), 1'($urandom_range(1)));
      run(d, "back_to_back", 1000);
    end
  endtask

  initial begin
    reset = 1'b1;
    sv_i = '0; sf_i = '0; tbd_i = '0; sy_i = '0;
    repeat (3) @(negedge clock);
    #1;
    test_reset();
    test_basic();
    test_acs3();
    test_idle_nosof();
    test_abort();
    test_tbwait();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
